// File: rtl/rbe_binconv_sched.sv
// Step scheduler for one BinConv row: walks K iterations x activation tiles x
// (optional two offset steps + QW weight bit-planes). Optional perf counters: RBE_SCHED_PERF_CNT_EN.
module rbe_binconv_sched #(
  parameter int QW_MAX       = 8,
  parameter int QA_TILES_MAX = 2,
  parameter int K_ITER_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [$clog2(QW_MAX):0]    cfg_qw_i,
  input  logic [1:0]                 cfg_qa_tiles_i,
  input  logic [K_ITER_W-1:0]        cfg_k_iter_i,
  input  logic                       cfg_offset_en_i,
  input  logic                       step_ready_i,
  output logic                       step_valid_o,
  output logic [$clog2(QW_MAX)-1:0]  qw_idx_o,
  output logic                       qa_tile_sel_o,
  output logic                       offset_en_o,
  output logic                       offset_state_o,
  output logic [K_ITER_W-1:0]        k_idx_o,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef RBE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                step_cnt_o
`endif
);

  localparam int QW_W = $clog2(QW_MAX);

  typedef enum logic [1:0] {IDLE, OFFS, COMP, DONE} state_t;

  state_t              state_reg, state_next;
  logic [QW_W-1:0]     qw_idx_reg, qw_idx_next;
  logic                tile_reg, tile_next;
  logic [K_ITER_W-1:0] k_idx_reg, k_idx_next;
  logic                phase_reg, phase_next;
  logic [QW_W-1:0]     qw_last_reg, qw_last_next;
  logic                tile_last_reg, tile_last_next;
  logic [K_ITER_W-1:0] k_last_reg, k_last_next;
  logic                offset_reg, offset_next;

  logic [QW_W:0] qw_eff;
  logic [1:0]    tiles_eff;
  logic          accept;
  logic          qw_wrap;
  logic          tile_wrap;
  logic          k_wrap;

  // Out-of-range configuration is folded into [1, MAX] before latching.
  assign qw_eff = (cfg_qw_i == '0) ? (QW_W+1)'(1) :
                  (cfg_qw_i > (QW_W+1)'(QW_MAX)) ? (QW_W+1)'(QW_MAX) : cfg_qw_i;
  assign tiles_eff = (cfg_qa_tiles_i == 2'd0) ? 2'd1 :
                     (cfg_qa_tiles_i > 2'(QA_TILES_MAX)) ? 2'(QA_TILES_MAX) : cfg_qa_tiles_i;

  assign step_valid_o   = (state_reg == OFFS) || (state_reg == COMP);
  assign accept         = step_valid_o && step_ready_i;
  assign qw_wrap        = (qw_idx_reg == qw_last_reg);
  assign tile_wrap      = (tile_reg == tile_last_reg);
  assign k_wrap         = (k_idx_reg == k_last_reg);

  assign qw_idx_o       = (state_reg == COMP) ? qw_idx_reg : '0;
  assign qa_tile_sel_o  = tile_reg;
  assign offset_en_o    = (state_reg == OFFS);
  assign offset_state_o = (state_reg == OFFS) && phase_reg;
  assign k_idx_o        = k_idx_reg;
  assign last_o         = (state_reg == COMP) && qw_wrap && tile_wrap && k_wrap;
  assign busy_o         = (state_reg != IDLE);
  assign done_o         = (state_reg == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      qw_idx_reg    <= '0;
      tile_reg      <= 1'b0;
      k_idx_reg     <= '0;
      phase_reg     <= 1'b0;
      qw_last_reg   <= '0;
      tile_last_reg <= 1'b0;
      k_last_reg    <= '0;
      offset_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      qw_idx_reg    <= qw_idx_next;
      tile_reg      <= tile_next;
      k_idx_reg     <= k_idx_next;
      phase_reg     <= phase_next;
      qw_last_reg   <= qw_last_next;
      tile_last_reg <= tile_last_next;
      k_last_reg    <= k_last_next;
      offset_reg    <= offset_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    qw_idx_next    = qw_idx_reg;
    tile_next      = tile_reg;
    k_idx_next     = k_idx_reg;
    phase_next     = phase_reg;
    qw_last_next   = qw_last_reg;
    tile_last_next = tile_last_reg;
    k_last_next    = k_last_reg;
    offset_next    = offset_reg;
    if (clear_i) begin
      state_next  = IDLE;
      qw_idx_next = '0;
      tile_next   = 1'b0;
      k_idx_next  = '0;
      phase_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            qw_last_next   = QW_W'(qw_eff - 1'b1);
            tile_last_next = 1'(tiles_eff - 2'd1);
            k_last_next    = cfg_k_iter_i - 1'b1;
            offset_next    = cfg_offset_en_i;
            if (cfg_k_iter_i == '0) state_next = DONE;
            else if (cfg_offset_en_i) state_next = OFFS;
            else state_next = COMP;
          end
        end
        OFFS: begin
          if (accept) begin
            phase_next = ~phase_reg;
            if (phase_reg) state_next = COMP;
          end
        end
        COMP: begin
          if (accept) begin
            if (!qw_wrap) begin
              qw_idx_next = qw_idx_reg + 1'b1;
            end else begin
              qw_idx_next = '0;
              state_next  = offset_reg ? OFFS : COMP;
              if (!tile_wrap) begin
                tile_next = tile_reg + 1'b1;
              end else begin
                tile_next = 1'b0;
                if (!k_wrap) begin
                  k_idx_next = k_idx_reg + 1'b1;
                end else begin
                  // Counters are already back at zero when DONE is entered.
                  k_idx_next = '0;
                  state_next = DONE;
                end
              end
            end
          end
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef RBE_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] step_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      step_cnt_reg  <= '0;
    end else if (clear_i || ((state_reg == IDLE) && start_i)) begin
      stall_cnt_reg <= '0;
      step_cnt_reg  <= '0;
    end else begin
      if (step_valid_o && !step_ready_i && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (accept && !(&step_cnt_reg)) step_cnt_reg <= step_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign step_cnt_o  = step_cnt_reg;
`endif

endmodule
